// File: rtl/inst_prefetch_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_prefetch_buf_if
// Description : Bundles the CPU fetch port and the instruction memory read
//               port seen by inst_prefetch_buf.
//               slave  - the prefetch buffer side
//               master - the CPU + memory side
//               Signals:
//                 cpu_ce_i / cpu_addr_i / cpu_hold_i : fetch request
//                 cpu_data_o / stall_req_o           : fetch response
//                 mem_ce_o / mem_addr_o              : memory read issue
//                 mem_data_i                         : memory read data
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_prefetch_buf_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_ce_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic              cpu_hold_i;
    logic [DATA_W-1:0] cpu_data_o;
    logic              stall_req_o;
    logic              mem_ce_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_i;

    modport slave (
        input  cpu_ce_i, cpu_addr_i, cpu_hold_i, mem_data_i,
        output cpu_data_o, stall_req_o, mem_ce_o, mem_addr_o
    );

    modport master (
        output cpu_ce_i, cpu_addr_i, cpu_hold_i, mem_data_i,
        input  cpu_data_o, stall_req_o, mem_ce_o, mem_addr_o
    );
endinterface
`default_nettype wire

// File: rtl/inst_prefetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : inst_prefetch_buf
// Description : Instruction prefetch buffer between the CPU fetch port and a
//               pipelined fixed-latency instruction memory. Sequential words
//               are fetched ahead of the PC into a FIFO; the head is served
//               in one cycle when its address matches the CPU request, and
//               any unexpected address redirects the stream.
//               Ports:
//                 clk  - rising-edge clock
//                 rst  - asynchronous active-low reset
//                 bus  - inst_prefetch_buf_if.slave (CPU and memory ports)
// Revision    : 1.0 - initial release
// ============================================================================
module inst_prefetch_buf #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int MEM_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    inst_prefetch_buf_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CR_W  = CNT_W + 1;

    // FIFO of returned {addr, data}
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] fetch_ptr;

    // In-flight reads: stage 0 is the newest, stage MEM_LAT-1 returns now
    logic [MEM_LAT-1:0] fl_vld;
    logic [ADDR_W-1:0]  fl_addr [MEM_LAT];

    logic              active;
    logic              hit;
    logic              pending;
    logic              miss;
    logic              pop;
    logic              push;
    logic              issue;
    logic              oldest_vld;
    logic [ADDR_W-1:0] oldest_addr;
    logic [CR_W-1:0]   fl_cnt;
    logic [CR_W-1:0]   credit;

    // Oldest valid in-flight stage and number of reads in flight
    always_comb begin
        oldest_vld  = 1'b0;
        oldest_addr = '0;
        fl_cnt      = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            if (fl_vld[i]) begin
                oldest_vld  = 1'b1;
                oldest_addr = fl_addr[i];
                fl_cnt      = fl_cnt + CR_W'(1);
            end
        end
    end

    always_comb begin
        // Reset is folded in so every output reads zero while rst is low
        active  = bus.cpu_ce_i & rst;
        hit     = active && (count != '0) && (fifo_addr[head] == bus.cpu_addr_i);
        // With an empty FIFO the oldest in-flight read is the next word due;
        // if it is the requested one, just wait for it instead of redirecting.
        pending = active && !hit && (count == '0) && oldest_vld
                  && (oldest_addr == bus.cpu_addr_i);
        miss    = active && !hit && !pending;
        pop     = hit && !bus.cpu_hold_i;
        // A redirect drops whatever returns in the same cycle
        push    = fl_vld[MEM_LAT-1] && !miss;
        // Slots already committed once this cycle's pop is accounted for;
        // issuing only below DEPTH guarantees every return has room.
        credit  = CR_W'(count) + fl_cnt - CR_W'(pop);
        issue   = miss || (active && (credit < CR_W'(DEPTH)));

        bus.mem_ce_o    = issue;
        bus.mem_addr_o  = miss ? bus.cpu_addr_i : (issue ? fetch_ptr : '0);
        bus.stall_req_o = active && !hit;
        bus.cpu_data_o  = hit ? fifo_data[head] : '0;
    end

    // Control state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            fetch_ptr <= '0;
            fl_vld    <= '0;
        end else begin
            for (int i = MEM_LAT - 1; i > 0; i--) begin
                fl_vld[i] <= fl_vld[i-1] && !miss;
            end
            fl_vld[0] <= issue;

            if (miss) begin
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                fetch_ptr <= bus.cpu_addr_i + ADDR_W'(4);
            end else begin
                if (issue) begin
                    fetch_ptr <= fetch_ptr + ADDR_W'(4);
                end
                if (push) begin
                    tail <= tail + PTR_W'(1);
                end
                if (pop) begin
                    head <= head + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

    // Storage: contents are qualified by count / fl_vld, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[tail] <= fl_addr[MEM_LAT-1];
            fifo_data[tail] <= bus.mem_data_i;
        end
        for (int i = MEM_LAT - 1; i > 0; i--) begin
            fl_addr[i] <= fl_addr[i-1];
        end
        fl_addr[0] <= bus.mem_addr_o;
    end
endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_prefetch_buf
// Description : Directed bench for inst_prefetch_buf (DEPTH=4, MEM_LAT=2).
//               The memory model returns the read address as data, MEM_LAT
//               cycles after issue. Each cycle drives the CPU request and
//               compares stall/data (and optionally the memory issue) against
//               hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_prefetch_buf;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;
    localparam int MEM_LAT = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   cyc_no = 0;

    inst_prefetch_buf_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    inst_prefetch_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Pipelined memory: word content equals its address
    logic [31:0] mpipe [MEM_LAT];
    always @(posedge clk) begin
        mpipe[0] <= bus.mem_ce_o ? bus.mem_addr_o : 32'hDEAD_BEEF;
        for (int i = 1; i < MEM_LAT; i++) begin
            mpipe[i] <= mpipe[i-1];
        end
    end
    assign bus.mem_data_i = mpipe[MEM_LAT-1];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle's request, then compare at the falling edge
    task automatic cyc(input logic ce, input logic [31:0] addr, input logic hold,
                       input logic exp_stall, input logic [31:0] exp_data);
        bus.cpu_ce_i   = ce;
        bus.cpu_addr_i = addr;
        bus.cpu_hold_i = hold;
        @(negedge clk);
        check_val($sformatf("c%0d.stall", cyc_no), {31'b0, bus.stall_req_o}, {31'b0, exp_stall});
        check_val($sformatf("c%0d.data", cyc_no), bus.cpu_data_o, exp_data);
    endtask

    task automatic mem_chk(input logic exp_ce, input logic [31:0] exp_addr);
        check_val($sformatf("c%0d.mem_ce", cyc_no), {31'b0, bus.mem_ce_o}, {31'b0, exp_ce});
        check_val($sformatf("c%0d.mem_addr", cyc_no), bus.mem_addr_o, exp_addr);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    initial begin
        rst            = 1'b0;
        bus.cpu_ce_i   = 1'b1;
        bus.cpu_addr_i = 32'h0;
        bus.cpu_hold_i = 1'b0;

        // Reset state with a live fetch request
        @(negedge clk);
        check_val("rst.stall", {31'b0, bus.stall_req_o}, 32'h0);
        check_val("rst.data", bus.cpu_data_o, 32'h0);
        mem_chk(1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Cold start: c0 miss, c1-c2 pending, stream from c3
        cyc(1, 32'h0, 0, 1, 32'h0); mem_chk(1'b1, 32'h0); next_cyc();
        cyc(1, 32'h0, 0, 1, 32'h0); mem_chk(1'b1, 32'h4); next_cyc();
        cyc(1, 32'h0, 0, 1, 32'h0); mem_chk(1'b1, 32'h8); next_cyc();
        for (int k = 0; k < 5; k++) begin
            cyc(1, 32'(k * 4), 0, 0, 32'(k * 4)); next_cyc();
        end

        // Branch to 0x200 from the stream (head holds 0x14)
        cyc(1, 32'h200, 0, 1, 32'h0); mem_chk(1'b1, 32'h200); next_cyc();
        cyc(1, 32'h200, 0, 1, 32'h0); next_cyc();
        cyc(1, 32'h200, 0, 1, 32'h0); next_cyc();
        for (int k = 0; k < 3; k++) begin
            cyc(1, 32'h200 + 32'(k * 4), 0, 0, 32'h200 + 32'(k * 4)); next_cyc();
        end

        // Jump to 0x20, then hold for 10 cycles
        for (int k = 0; k < 3; k++) begin
            cyc(1, 32'h20, 0, 1, 32'h0); next_cyc();
        end
        cyc(1, 32'h20, 1, 0, 32'h20); mem_chk(1'b1, 32'h2C); next_cyc();
        cyc(1, 32'h20, 1, 0, 32'h20); mem_chk(1'b0, 32'h0);  next_cyc();
        for (int k = 0; k < 8; k++) begin
            cyc(1, 32'h20, 1, 0, 32'h20); next_cyc();
        end
        check_val("hold.mem_ce", {31'b0, bus.mem_ce_o}, 32'h0);
        cyc(1, 32'h20, 0, 0, 32'h20); mem_chk(1'b1, 32'h30); next_cyc();
        for (int k = 1; k < 5; k++) begin
            cyc(1, 32'h20 + 32'(k * 4), 0, 0, 32'h20 + 32'(k * 4)); next_cyc();
        end

        // Back-to-back redirects 0x100 then 0x300
        cyc(1, 32'h100, 0, 1, 32'h0); mem_chk(1'b1, 32'h100); next_cyc();
        cyc(1, 32'h300, 0, 1, 32'h0); mem_chk(1'b1, 32'h300); next_cyc();
        cyc(1, 32'h300, 0, 1, 32'h0); next_cyc();
        cyc(1, 32'h300, 0, 1, 32'h0); next_cyc();
        cyc(1, 32'h300, 0, 0, 32'h300); next_cyc();
        cyc(1, 32'h304, 0, 0, 32'h304); next_cyc();

        // Address wrap
        cyc(1, 32'hFFFF_FFF8, 0, 1, 32'h0); mem_chk(1'b1, 32'hFFFF_FFF8); next_cyc();
        cyc(1, 32'hFFFF_FFF8, 0, 1, 32'h0); mem_chk(1'b1, 32'hFFFF_FFFC); next_cyc();
        cyc(1, 32'hFFFF_FFF8, 0, 1, 32'h0); mem_chk(1'b1, 32'h0);         next_cyc();
        cyc(1, 32'hFFFF_FFF8, 0, 0, 32'hFFFF_FFF8); next_cyc();
        cyc(1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC); next_cyc();
        cyc(1, 32'h0, 0, 0, 32'h0); next_cyc();
        cyc(1, 32'h4, 0, 0, 32'h4); next_cyc();
        cyc(1, 32'h8, 0, 0, 32'h8); mem_chk(1'b1, 32'h14); next_cyc();

        // Reset mid-stream with reads for 0x10 and 0x14 in flight
        bus.cpu_ce_i   = 1'b1;
        bus.cpu_addr_i = 32'hC;
        rst            = 1'b0;
        @(negedge clk);
        check_val("mrst.stall", {31'b0, bus.stall_req_o}, 32'h0);
        check_val("mrst.data", bus.cpu_data_o, 32'h0);
        mem_chk(1'b0, 32'h0);
        next_cyc();
        rst = 1'b1;
        // Stale 0x14 returns this cycle and must not be captured
        cyc(0, 32'h14, 0, 0, 32'h0); mem_chk(1'b0, 32'h0); next_cyc();
        cyc(1, 32'h14, 0, 1, 32'h0); mem_chk(1'b1, 32'h14); next_cyc();
        cyc(1, 32'h14, 0, 1, 32'h0); next_cyc();
        cyc(1, 32'h14, 0, 1, 32'h0); next_cyc();
        cyc(1, 32'h14, 0, 0, 32'h14); next_cyc();
        cyc(1, 32'h18, 0, 0, 32'h18); next_cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
